// File: rtl/rsa_stream_crypter.sv
// RSA stream engine: packs serial RX bits into blocks for an external modular exponentiator
// and streams the results back out to TX as bytes, with end-of-stream flush and bad-key detection.
module rsa_stream_crypter #(
    parameter int KEY_W = 32,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             start,
    input  logic             eos,
    input  logic [KEY_W-1:0] n_key,
    input  logic [KEY_W-1:0] e_key,
    input  logic [KEY_W-1:0] d_key,
    input  logic             data_in,
    input  logic             ready_in,
    output logic             clear_rx_flag,
    output logic             fme_start,
    output logic [KEY_W-1:0] fme_base,
    output logic [KEY_W-1:0] fme_exp,
    input  logic             fme_done,
    input  logic [KEY_W-1:0] fme_result,
    input  logic             ready_out,
    output logic             start_out,
    output logic [7:0]       data_out,
    output logic [LEN_W-1:0] n_len_out,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_COLLECT, S_RUN, S_EMIT, S_FLUSH, S_DONE
    } state_t;

    state_t           state;
    logic             mode_r;
    logic             last;
    logic             guard;
    logic [LEN_W-1:0] blk_len;
    logic [LEN_W-1:0] emit_len;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] emit_cnt;
    logic [KEY_W-1:0] blk;
    logic [KEY_W-1:0] res;
    logic [7:0]       acc;
    logic [3:0]       acc_cnt;

    // Bit length of the modulus: index of the highest set bit plus one (0 for n_key == 0).
    function automatic logic [LEN_W-1:0] msb_len(input logic [KEY_W-1:0] v);
        logic [LEN_W-1:0] len;
        len = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (v[i]) len = LEN_W'(i + 1);
        end
        return len;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            mode_r        <= 1'b0;
            last          <= 1'b0;
            guard         <= 1'b0;
            blk_len       <= '0;
            emit_len      <= '0;
            bit_cnt       <= '0;
            emit_cnt      <= '0;
            blk           <= '0;
            res           <= '0;
            acc           <= '0;
            acc_cnt       <= '0;
            clear_rx_flag <= 1'b0;
            fme_start     <= 1'b0;
            fme_base      <= '0;
            fme_exp       <= '0;
            start_out     <= 1'b0;
            data_out      <= '0;
            n_len_out     <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            clear_rx_flag <= 1'b0;
            fme_start     <= 1'b0;
            start_out     <= 1'b0;
            // The guard cycle is the one right after the start_out pulse has dropped.
            if (!start_out && guard) guard <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        n_len_out <= msb_len(n_key);
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (n_len_out < LEN_W'(2)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        blk_len  <= mode_r ? n_len_out - LEN_W'(1) : LEN_W'(KEY_W);
                        emit_len <= mode_r ? LEN_W'(KEY_W) : n_len_out - LEN_W'(1);
                        fme_exp  <= mode_r ? e_key : d_key;
                        blk      <= '0;
                        bit_cnt  <= '0;
                        last     <= 1'b0;
                        acc      <= '0;
                        acc_cnt  <= '0;
                        state    <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    // A pending RX bit always wins over eos; bits not yet received stay zero (padding).
                    if (bit_cnt == blk_len || (!ready_in && eos && bit_cnt != '0)) begin
                        fme_start <= 1'b1;
                        fme_base  <= blk;
                        last      <= (bit_cnt != blk_len);
                        blk       <= '0;
                        bit_cnt   <= '0;
                        state     <= S_RUN;
                    end else if (ready_in) begin
                        // While the acknowledge is out, the RX flag has not dropped yet.
                        if (!clear_rx_flag) begin
                            blk           <= blk | (KEY_W'(data_in) << bit_cnt);
                            bit_cnt       <= bit_cnt + LEN_W'(1);
                            clear_rx_flag <= 1'b1;
                        end
                    end else if (eos) begin
                        state <= S_FLUSH;
                    end
                end

                S_RUN: begin
                    if (fme_done) begin
                        res      <= fme_result;
                        emit_cnt <= '0;
                        state    <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    // Result bits enter the byte accumulator LSB-first; a partial byte carries over.
                    if (acc_cnt == 4'd8) begin
                        if (!start_out && !guard && ready_out) begin
                            start_out <= 1'b1;
                            data_out  <= acc;
                            acc_cnt   <= '0;
                            guard     <= 1'b1;
                        end
                    end else if (emit_cnt != emit_len) begin
                        acc      <= {res[0], acc[7:1]};
                        res      <= res >> 1;
                        acc_cnt  <= acc_cnt + 4'd1;
                        emit_cnt <= emit_cnt + LEN_W'(1);
                    end else if (!start_out && !guard) begin
                        state <= last ? S_FLUSH : S_COLLECT;
                    end
                end

                S_FLUSH: begin
                    acc     <= '0;
                    acc_cnt <= '0;
                    state   <= S_DONE;
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_stream_crypter.sv
// Scoreboard bench for rsa_stream_crypter: behavioural exponentiator, RX and TX models,
// expected block values and bytes queued at stimulus time and compared at the outputs.
module tb_rsa_stream_crypter;

    localparam int KEY_W = 32;
    localparam int LEN_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic             start;
    logic             eos;
    logic [KEY_W-1:0] n_key;
    logic [KEY_W-1:0] e_key;
    logic [KEY_W-1:0] d_key;
    logic             data_in;
    logic             ready_in;
    logic             clear_rx_flag;
    logic             fme_start;
    logic [KEY_W-1:0] fme_base;
    logic [KEY_W-1:0] fme_exp;
    logic             fme_done;
    logic [KEY_W-1:0] fme_result;
    logic             ready_out;
    logic             start_out;
    logic [7:0]       data_out;
    logic [LEN_W-1:0] n_len_out;
    logic             busy;
    logic             err;

    rsa_stream_crypter #(.KEY_W(KEY_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .eos(eos),
        .n_key(n_key), .e_key(e_key), .d_key(d_key),
        .data_in(data_in), .ready_in(ready_in), .clear_rx_flag(clear_rx_flag),
        .fme_start(fme_start), .fme_base(fme_base), .fme_exp(fme_exp),
        .fme_done(fme_done), .fme_result(fme_result),
        .ready_out(ready_out), .start_out(start_out), .data_out(data_out),
        .n_len_out(n_len_out), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_clear_cyc = 0;
    int last_out_cyc = -1;
    int hold_until = 0;
    int tx_busy;
    logic chk_lat = 1'b0;
    logic rdy_q = 1'b0;
    logic [KEY_W-1:0] cur_exp = '0;

    logic [7:0]       exp_bytes[$];
    logic [KEY_W-1:0] exp_base[$];
    logic             dec_bits[$];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_q <= ready_out;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [63:0] modexp(input logic [63:0] b_in, input logic [63:0] e, input logic [63:0] m);
        logic [63:0] r;
        logic [63:0] b;
        r = 64'd1 % m;
        b = b_in % m;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r;
    endfunction

    // Exponentiator: 5-cycle latency, result computed from operands captured at fme_start.
    initial begin
        logic [63:0] b, x, m;
        fme_done   = 1'b0;
        fme_result = '0;
        forever begin
            @(negedge clk);
            if (fme_start && !rst) begin
                b = 64'(fme_base);
                x = 64'(fme_exp);
                m = 64'(n_key);
                repeat (4) @(negedge clk);
                if (busy) check_eq("fme_base_stable", 64'(fme_base), b);
                fme_result = KEY_W'(modexp(b, x, m));
                fme_done   = 1'b1;
                @(negedge clk);
                fme_done   = 1'b0;
            end
        end
    end

    // TX: busy for one cycle after each byte, optionally held off until hold_until.
    initial begin
        tx_busy   = 0;
        ready_out = 1'b1;
        forever begin
            @(negedge clk);
            if (start_out) tx_busy = 1;
            else if (tx_busy > 0) tx_busy--;
            ready_out = (tx_busy == 0) && (cyc >= hold_until);
        end
    end

    // Output monitor: bytes and exponentiator launches against the scoreboard.
    always @(negedge clk) begin
        if (!rst && start_out) begin
            check_eq("tx_ready_before_pulse", 64'(rdy_q), 64'd1);
            if (last_out_cyc >= 0) check_eq("guard_gap", 64'((cyc - last_out_cyc) >= 2), 64'd1);
            last_out_cyc = cyc;
            if (exp_bytes.size() == 0) check_eq("spurious_start_out", 64'(start_out), 64'd0);
            else check_eq("byte", 64'(data_out), 64'(exp_bytes.pop_front()));
        end
        if (!rst && fme_start) begin
            if (exp_base.size() == 0) check_eq("spurious_fme_start", 64'(fme_start), 64'd0);
            else check_eq("fme_base", 64'(fme_base), 64'(exp_base.pop_front()));
            check_eq("fme_exp", 64'(fme_exp), 64'(cur_exp));
            if (chk_lat) check_eq("fme_start_latency", 64'(cyc - last_clear_cyc), 64'd1);
        end
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; eos = 1'b0; ready_in = 1'b0; data_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_bytes.delete(); exp_base.delete(); dec_bits.delete();
        last_out_cyc = -1;
    endtask

    task automatic start_op(input logic [KEY_W-1:0] n, input logic m);
        n_key = n; mode = m;
        cur_exp = m ? e_key : d_key;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int n;
        @(negedge clk);
        data_in = b; ready_in = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!clear_rx_flag && n < 400);
        if (!clear_rx_flag) check_eq("rx_ack_timeout", 64'(clear_rx_flag), 64'd1);
        last_clear_cyc = cyc;
        ready_in = 1'b0;
    endtask

    task automatic send_bits(input logic [KEY_W-1:0] v, input int cnt);
        for (int i = 0; i < cnt; i++) send_bit(v[i]);
    endtask

    task automatic push_enc(input logic [KEY_W-1:0] plain);
        logic [KEY_W-1:0] c;
        c = KEY_W'(modexp(64'(plain), 64'd17, 64'd3233));
        exp_base.push_back(plain);
        for (int k = 0; k < KEY_W/8; k++) exp_bytes.push_back(c[8*k +: 8]);
    endtask

    // Decrypt output: the 11 plaintext bits of each block form one continuous LSB-first stream.
    task automatic push_dec(input logic [KEY_W-1:0] cipher, input logic [KEY_W-1:0] plain);
        logic [7:0] byte_v;
        exp_base.push_back(cipher);
        for (int i = 0; i < 11; i++) dec_bits.push_back(plain[i]);
        while (dec_bits.size() >= 8) begin
            for (int k = 0; k < 8; k++) byte_v[k] = dec_bits.pop_front();
            exp_bytes.push_back(byte_v);
        end
    endtask

    task automatic finish_stream(input string tag);
        int n;
        eos = 1'b1; n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        check_eq(tag, 64'(busy), 64'd0);
        eos = 1'b0;
        dec_bits.delete();
        check_eq({tag, "_bytes_left"}, 64'(exp_bytes.size()), 64'd0);
        check_eq({tag, "_blocks_left"}, 64'(exp_base.size()), 64'd0);
    endtask

    initial begin
        int n;
        logic [KEY_W-1:0] c2;
        e_key = 32'd17; d_key = 32'd2753; n_key = 32'd3233; mode = 1'b1;
        do_reset();
        check_eq("reset_outputs",
                 64'({clear_rx_flag, fme_start, start_out, busy, err, data_out, n_len_out}), 64'd0);
        check_eq("reset_fme_base", 64'(fme_base), 64'd0);

        // 1: encrypt 65 -> 2790, bytes E6 0A 00 00
        chk_lat = 1'b1;
        exp_base.push_back(32'd65);
        exp_bytes.push_back(8'hE6); exp_bytes.push_back(8'h0A);
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h00);
        start_op(32'd3233, 1'b1);
        check_eq("n_len_out", 64'(n_len_out), 64'd12);
        check_eq("busy_after_start", 64'(busy), 64'd1);
        send_bits(32'd65, 11);
        finish_stream("t1_done");

        // 2: decrypt 2790 -> 65, one byte 0x41
        push_dec(32'd2790, 32'd65);
        start_op(32'd3233, 1'b0);
        send_bits(32'd2790, 32);
        finish_stream("t2_done");

        // 2b: two decrypt blocks, remainder bits carry across blocks
        c2 = KEY_W'(modexp(64'd1234, 64'd17, 64'd3233));
        push_dec(32'd2790, 32'd65);
        push_dec(c2, 32'd1234);
        start_op(32'd3233, 1'b0);
        send_bits(32'd2790, 32);
        send_bits(c2, 32);
        finish_stream("t2b_done");

        // 3: partial encrypt block padded at eos
        chk_lat = 1'b0;
        push_enc(32'h15);
        start_op(32'd3233, 1'b1);
        send_bits(32'b10101, 5);
        finish_stream("t3_done");

        // 4: bad key, then a good start clears err
        start_op(32'd1, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("bad_key_err", 64'(err), 64'd1);
        check_eq("bad_key_busy", 64'(busy), 64'd0);
        check_eq("bad_key_n_len", 64'(n_len_out), 64'd1);
        start_op(32'd3233, 1'b1);
        check_eq("err_cleared", 64'(err), 64'd0);
        finish_stream("t4_done");

        // 5: TX held off for 20 cycles during EMIT
        push_enc(32'd1234);
        start_op(32'd3233, 1'b1);
        send_bits(32'd1234, 11);
        hold_until = cyc + 20;
        n = 0;
        while (!start_out && n < 200) begin @(negedge clk); n++; end
        check_eq("hold_respected", 64'(cyc >= hold_until), 64'd1);
        finish_stream("t5_done");

        // 6: reset during RUN aborts; the late fme_done is ignored
        push_enc(32'd1234);
        start_op(32'd3233, 1'b1);
        send_bits(32'd1234, 11);
        n = 0;
        while (!fme_start && n < 50) begin @(negedge clk); n++; end
        check_eq("t6_fme_start_seen", 64'(fme_start), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        exp_bytes.delete();
        @(negedge clk);
        check_eq("abort_outputs",
                 64'({clear_rx_flag, fme_start, start_out, busy, err, data_out, n_len_out}), 64'd0);
        check_eq("abort_fme_regs", 64'({fme_base, fme_exp}), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("abort_stays_idle", 64'(busy), 64'd0);
        exp_base.push_back(32'd65);
        exp_bytes.push_back(8'hE6); exp_bytes.push_back(8'h0A);
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h00);
        start_op(32'd3233, 1'b1);
        send_bits(32'd65, 11);
        finish_stream("t6_restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
